// File: rtl/systolic_pkg.sv
// Shared types and constants for the systolic convolution stream front end:
// element widths, operand/result counts, bus widths and the frame FSM states.
package systolic_pkg;

  localparam int DATA_W = 8;
  localparam int N_ACT  = 16;
  localparam int N_FLT  = 9;
  localparam int N_RES  = 4;

  localparam int ACT_W  = DATA_W * N_ACT;
  localparam int FLT_W  = DATA_W * N_FLT;
  localparam int RES_W  = DATA_W * N_RES;
  localparam int IDX_W  = $clog2(N_RES);

  // Element indices of the last activation byte and of the last filter byte.
  localparam int LAST_ACT_IDX = N_ACT - 1;
  localparam int LAST_FLT_IDX = N_ACT + N_FLT - 1;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    SEND = 2'd2
  } state_e;

endpackage

// File: rtl/systolic_result_serializer.sv
// Holds the captured engine results and streams them out o00, o01, o10, o11
// with a valid/ready handshake; done pulses on the final handshake.
module systolic_result_serializer
  import systolic_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic [RES_W-1:0]  res_in,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              done
);

  logic [RES_W-1:0] res_q, res_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             m_valid_q, m_valid_d;
  logic             last_byte;

  assign last_byte = (idx_q == IDX_W'(N_RES - 1));

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latches).
    res_d     = res_q;
    idx_d     = idx_q;
    m_valid_d = m_valid_q;
    done      = 1'b0;
    if (capture) begin
      res_d     = res_in;
      idx_d     = '0;
      m_valid_d = 1'b1;
    end else if (m_valid_q && m_ready) begin
      if (last_byte) begin
        idx_d     = '0;
        m_valid_d = 1'b0;
        done      = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      res_q     <= '0;
      idx_q     <= '0;
      m_valid_q <= 1'b0;
    end else begin
      res_q     <= res_d;
      idx_q     <= idx_d;
      m_valid_q <= m_valid_d;
    end
  end

  always_comb begin
    m_data = res_q[RES_W-1 -: DATA_W];
    case (idx_q)
      2'd1:    m_data = res_q[RES_W-1-DATA_W   -: DATA_W];
      2'd2:    m_data = res_q[RES_W-1-2*DATA_W -: DATA_W];
      2'd3:    m_data = res_q[RES_W-1-3*DATA_W -: DATA_W];
      default: m_data = res_q[RES_W-1 -: DATA_W];
    endcase
  end

  assign m_valid = m_valid_q;
  assign m_last  = m_valid_q && last_byte;

endmodule

// File: rtl/systolic_stream_frontend.sv
// Byte-stream front end for the systolic convolution engines: LOAD operands,
// RUN the engine for LATENCY cycles, SEND four result bytes.
// Define FRONTEND_FILTER_REUSE_EN to keep the filter and load only 16 bytes after the first frame.
module systolic_stream_frontend
  import systolic_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int LATENCY = 12
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              s_valid,
  output logic              s_ready,
  input  logic [DATA_W-1:0] s_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [DATA_W-1:0] m_data,
  output logic              m_last,
  output logic              eng_rst,
  output logic [ACT_W-1:0]  act_bus,
  output logic [FLT_W-1:0]  flt_bus,
  input  logic [RES_W-1:0]  res_bus
);

  if (DATA_W != systolic_pkg::DATA_W) begin : g_bad_data_w
    $error("systolic_stream_frontend: only DATA_W = 8 is supported");
  end
  if (LATENCY < 1) begin : g_bad_latency
    $error("systolic_stream_frontend: LATENCY must be >= 1");
  end

  localparam int CNT_W = ($clog2(LATENCY) > 5) ? $clog2(LATENCY) : 5;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACT_W-1:0] act_q, act_d;
  logic [FLT_W-1:0] flt_q, flt_d;
  logic             s_ready_q, s_ready_d;
  logic             accept;
  logic             capture;
  logic             ser_done;
  logic [CNT_W-1:0] last_idx;

`ifdef FRONTEND_FILTER_REUSE_EN
  logic flt_hold_q, flt_hold_d;

  always_comb begin
    flt_hold_d = flt_hold_q;
    if (state_q == LOAD && accept && cnt_q == CNT_W'(LAST_FLT_IDX)) begin
      flt_hold_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) flt_hold_q <= 1'b0;
    else      flt_hold_q <= flt_hold_d;
  end

  assign last_idx = flt_hold_q ? CNT_W'(LAST_ACT_IDX) : CNT_W'(LAST_FLT_IDX);
`else
  assign last_idx = CNT_W'(LAST_FLT_IDX);
`endif

  assign accept = s_valid && s_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    act_d   = act_q;
    flt_d   = flt_q;
    capture = 1'b0;
    case (state_q)
      LOAD: begin
        if (accept) begin
          for (int i = 0; i < N_ACT; i++) begin
            if (cnt_q == CNT_W'(i)) act_d[ACT_W-1-DATA_W*i -: DATA_W] = s_data;
          end
          for (int j = 0; j < N_FLT; j++) begin
            if (cnt_q == CNT_W'(N_ACT + j)) flt_d[FLT_W-1-DATA_W*j -: DATA_W] = s_data;
          end
          if (cnt_q == last_idx) begin
            cnt_d   = '0;
            state_d = RUN;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      end
      RUN: begin
        // cnt holds (RUN cycle number - 1); the final RUN cycle captures the results.
        if (cnt_q == CNT_W'(LATENCY - 1)) begin
          cnt_d   = '0;
          capture = 1'b1;
          state_d = SEND;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SEND: begin
        if (ser_done) state_d = LOAD;
      end
      default: state_d = LOAD;
    endcase
    s_ready_d = (state_d == LOAD);
  end

  // NOTE: the operand buses are registers that the engine reads directly, so they are
  // cleared on reset rather than left holding a partial frame.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= LOAD;
      cnt_q     <= '0;
      act_q     <= '0;
      flt_q     <= '0;
      s_ready_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      act_q     <= act_d;
      flt_q     <= flt_d;
      s_ready_q <= s_ready_d;
    end
  end

  systolic_result_serializer u_serializer (
    .clk     (clk),
    .rst     (rst),
    .capture (capture),
    .res_in  (res_bus),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .done    (ser_done)
  );

  assign s_ready = s_ready_q;
  assign eng_rst = (state_q != RUN);
  assign act_bus = act_q;
  assign flt_bus = flt_q;

endmodule

// File: tb/tb_systolic_stream_frontend.sv
// Directed bench for systolic_stream_frontend with a constant-result engine stub.
module tb_systolic_stream_frontend;

  localparam int LAT = 12;
`ifdef FRONTEND_FILTER_REUSE_EN
  localparam bit REUSE = 1'b1;
`else
  localparam bit REUSE = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         s_valid;
  logic         s_ready;
  logic [7:0]   s_data;
  logic         m_valid;
  logic         m_ready;
  logic [7:0]   m_data;
  logic         m_last;
  logic         eng_rst;
  logic [127:0] act_bus;
  logic [71:0]  flt_bus;
  logic [31:0]  res_bus;

  assign res_bus = 32'hA1B2C3D4;
  always #5 clk = ~clk;

  systolic_stream_frontend #(.DATA_W(8), .LATENCY(LAT)) dut (
    .clk     (clk),
    .rst     (rst),
    .s_valid (s_valid),
    .s_ready (s_ready),
    .s_data  (s_data),
    .m_valid (m_valid),
    .m_ready (m_ready),
    .m_data  (m_data),
    .m_last  (m_last),
    .eng_rst (eng_rst),
    .act_bus (act_bus),
    .flt_bus (flt_bus),
    .res_bus (res_bus)
  );

  int           n_cmp;
  int           n_fail;
  logic [7:0]   byte_q [25];
  logic [7:0]   res_exp [4];
  logic [127:0] exp_act;
  logic [71:0]  exp_flt;
  bit           flt_held;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int frame_len();
    return (REUSE && flt_held) ? 16 : 25;
  endfunction

  // Sends byte_q[first..last] (optionally with an idle cycle before each byte) and
  // updates the expected operand buses.
  task automatic send_bytes(input int first, input int last, input bit gaps);
    for (int k = first; k <= last; k++) begin
      if (gaps) begin
        s_valid = 1'b0;
        s_data  = 8'h5A;
        tick();
      end
      s_valid = 1'b1;
      s_data  = byte_q[k];
      check("s_ready_load", s_ready, 1'b1);
      tick();
      if (k < 16) exp_act[127-8*k -: 8] = byte_q[k];
      else        exp_flt[71-8*(k-16) -: 8] = byte_q[k];
    end
    s_valid = 1'b0;
    if (last == 24) flt_held = 1'b1;
  endtask

  task automatic wait_mvalid();
    int n = 0;
    while (m_valid !== 1'b1 && n < 60) begin
      tick();
      n++;
    end
    check("m_valid_timeout", m_valid, 1'b1);
  endtask

  task automatic drain_all();
    m_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      check("drain_m_valid", m_valid, 1'b1);
      check("drain_m_data", m_data, res_exp[b]);
      check("drain_m_last", m_last, (b == 3));
      tick();
    end
    check("drain_s_ready_after", s_ready, 1'b1);
    check("drain_m_valid_after", m_valid, 1'b0);
    m_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int  low_cnt;
    int  n;
    bit  mv_bad;

    n_cmp    = 0;
    n_fail   = 0;
    rst      = 1'b0;
    s_valid  = 1'b0;
    s_data   = 8'h00;
    m_ready  = 1'b0;
    flt_held = 1'b0;
    exp_act  = '0;
    exp_flt  = '0;
    res_exp  = '{8'hA1, 8'hB2, 8'hC3, 8'hD4};

    // Reset values
    repeat (3) tick();
    check("rst_s_ready", s_ready, 1'b0);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_data", m_data, 8'h00);
    check("rst_m_last", m_last, 1'b0);
    check("rst_eng_rst", eng_rst, 1'b1);
    check("rst_act_bus", act_bus, '0);
    check("rst_flt_bus", flt_bus, '0);
    rst = 1'b1;
    tick();
    check("s_ready_after_release", s_ready, 1'b1);

    // Load scenario: continuous s_valid, then s_valid held high with junk during RUN
    byte_q = '{8'd252, 8'd165, 8'd199, 8'd27, 8'd93, 8'd28, 8'd86, 8'd176,
               8'd149, 8'd110, 8'd113, 8'd249, 8'd234, 8'd207, 8'd29, 8'd30,
               8'd181, 8'd176, 8'd207, 8'd111, 8'd248, 8'd115, 8'd64, 8'd95, 8'd253};
    send_bytes(0, 24, 1'b0);
    s_valid = 1'b1;
    s_data  = 8'hEE;
    low_cnt = 0;
    mv_bad  = 1'b0;
    n       = 0;
    while (eng_rst === 1'b0 && n < 40) begin
      low_cnt++;
      if (m_valid !== 1'b0) mv_bad = 1'b1;
      tick();
      n++;
    end
    check("eng_rst_low_cycles", low_cnt, LAT);
    check("m_valid_during_run", mv_bad, 1'b0);
    check("m_valid_after_run", m_valid, 1'b1);
    check("load_act_bus", act_bus, exp_act);
    check("load_flt_bus", flt_bus, exp_flt);
    check("load_i00", act_bus[127:120], 8'd252);
    check("load_f22", flt_bus[7:0], 8'd253);
    check("send_s_ready", s_ready, 1'b0);
    s_valid = 1'b0;

    // Drain scenario
    drain_all();

    // Backpressure scenario: gapped input, 5-cycle stall on B2
    for (int k = 0; k < 25; k++) byte_q[k] = 8'(k * 11 + 7);
    send_bytes(0, frame_len() - 1, 1'b1);
    check("bp_act_bus", act_bus, exp_act);
    check("bp_flt_bus", flt_bus, exp_flt);
    wait_mvalid();
    check("bp_first_byte", m_data, 8'hA1);
    m_ready = 1'b1;
    tick();
    m_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      check("bp_stall_data", m_data, 8'hB2);
      check("bp_stall_valid", m_valid, 1'b1);
      check("bp_stall_last", m_last, 1'b0);
      tick();
    end
    check("bp_hold_data", m_data, 8'hB2);
    m_ready = 1'b1;
    tick();
    check("bp_c3", m_data, 8'hC3);
    tick();
    check("bp_d4", m_data, 8'hD4);
    check("bp_d4_last", m_last, 1'b1);
    tick();
    check("bp_done_s_ready", s_ready, 1'b1);
    check("bp_done_m_valid", m_valid, 1'b0);
    m_ready = 1'b0;

    // Reset mid-frame after 10 bytes
    for (int k = 0; k < 25; k++) byte_q[k] = 8'(k * 5 + 100);
    send_bytes(0, 9, 1'b0);
    rst      = 1'b0;
    flt_held = 1'b0;
    exp_act  = '0;
    exp_flt  = '0;
    tick();
    check("midrst_act_bus", act_bus, '0);
    check("midrst_flt_bus", flt_bus, '0);
    check("midrst_s_ready", s_ready, 1'b0);
    check("midrst_eng_rst", eng_rst, 1'b1);
    check("midrst_m_valid", m_valid, 1'b0);
    check("midrst_m_data", m_data, 8'h00);
    rst = 1'b1;
    tick();
    check("midrst_s_ready_release", s_ready, 1'b1);
    byte_q = '{8'd252, 8'd165, 8'd199, 8'd27, 8'd93, 8'd28, 8'd86, 8'd176,
               8'd149, 8'd110, 8'd113, 8'd249, 8'd234, 8'd207, 8'd29, 8'd30,
               8'd181, 8'd176, 8'd207, 8'd111, 8'd248, 8'd115, 8'd64, 8'd95, 8'd253};
    send_bytes(0, frame_len() - 1, 1'b0);
    check("reload_act_bus", act_bus, exp_act);
    check("reload_flt_bus", flt_bus, exp_flt);
    check("reload_eng_rst", eng_rst, 1'b0);

    // Reset during the 6th RUN cycle
    repeat (5) tick();
    check("run6_eng_rst", eng_rst, 1'b0);
    rst      = 1'b0;
    flt_held = 1'b0;
    exp_act  = '0;
    exp_flt  = '0;
    tick();
    check("runrst_eng_rst", eng_rst, 1'b1);
    check("runrst_m_valid", m_valid, 1'b0);
    check("runrst_act_bus", act_bus, '0);
    rst     = 1'b1;
    m_ready = 1'b1;
    mv_bad  = 1'b0;
    repeat (20) begin
      tick();
      if (m_valid !== 1'b0) mv_bad = 1'b1;
    end
    check("runrst_no_m_valid", mv_bad, 1'b0);
    check("runrst_s_ready", s_ready, 1'b1);
    m_ready = 1'b0;

    // Full frame followed by an activation-only frame
    send_bytes(0, frame_len() - 1, 1'b0);
    wait_mvalid();
    drain_all();
    for (int k = 0; k < 16; k++) byte_q[k] = 8'(k * 3 + 1);
    for (int k = 16; k < 25; k++) byte_q[k] = 8'(k * 9);
    n = frame_len();
    send_bytes(0, 15, 1'b0);
    check("reuse_eng_rst_after16", eng_rst, (n == 16) ? 1'b0 : 1'b1);
    check("reuse_flt_bus", flt_bus, exp_flt);
    check("reuse_act_bus", act_bus, exp_act);
    if (n > 16) send_bytes(16, 24, 1'b0);
    check("second_frame_run", eng_rst, 1'b0);
    check("second_frame_flt_bus", flt_bus, exp_flt);
    wait_mvalid();
    drain_all();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_stream_frontend.md
# systolic_stream_frontend

Stream-side front end for the 2x2-output, 3x3-filter systolic convolution engines. It deserializes a byte stream into the engine's parallel 4x4 activation and 3x3 filter operand buses. It then drives the engine's active-high reset to run one computation for a fixed window, captures the four 8-bit results, and serializes them back out as a byte stream. It sits between the system byte interface and any of the 1x1, 2x2 or 3x3 systolic variants, which share the same operand and result ports.

## Interface
- DATA_W, 8, element width; only 8 is supported.
- LATENCY, 12, engine cycles from `eng_rst` deassertion to valid results; must be ≥1, elaboration error otherwise.
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-low reset
- s_valid  in  1  input byte valid
- s_ready  out  1  frontend accepts input byte
- s_data  in  8  input byte
- m_valid  out  1  result byte valid
- m_ready  in  1  downstream accepts result byte
- m_data  out  8  result byte
- m_last  out  1  marks the 4th result byte of a frame
- eng_rst  out  1  active-high reset to the systolic engine
- act_bus  out  128  i00 at [127:120] … i33 at [7:0], row-major
- flt_bus  out  72  f00 at [71:64] … f22 at [7:0], row-major
- res_bus  in  32  o00 [31:24], o01 [23:16], o10 [15:8], o11 [7:0]

## Operation
- FSM states are LOAD, RUN and SEND.
- LOAD
  - `s_ready`=1 and `eng_rst`=1.
  - Each accepted byte (`s_valid && s_ready`) is written to element index `cnt`.
  - Indices 0–15 go to `act_bus` (i00…i33); indices 16–24 go to `flt_bus` (f00…f22).
  - The accept at `cnt`=24 clears `cnt` and moves to RUN.
- RUN
  - `s_ready`=0 and `eng_rst`=0; `cnt` counts cycles.
  - On the LATENCY-th RUN cycle, `res_bus` is latched into the result register, `eng_rst` returns to 1 and the FSM moves to SEND.
- SEND
  - `m_valid`=1 and `m_data` = result byte `idx` (o00, o01, o10, o11).
  - `idx` advances on each `m_valid && m_ready`.
  - `m_last`=1 when `idx`=3; a handshake at `idx`=3 moves the FSM to LOAD.
- Operand buses hold their values outside LOAD writes. The engine sees stable operands for the whole RUN window.
- Inputs are ignored while `s_ready`=0, and no data is dropped. `m_data`, `m_last` and `m_valid` hold while `m_valid && !m_ready`.

## Timing
- Reset values
  - State LOAD, `cnt`=0, `idx`=0.
  - `s_ready`=0 during reset, then 1 on the first cycle after reset release.
  - `m_valid`=0, `m_data`=0, `m_last`=0, `eng_rst`=1.
  - `act_bus`=0, `flt_bus`=0, result register 0.
- `s_ready` and `m_valid` are decoded from registered state (no combinational path from `s_valid` or `m_ready`).
- Last input accept at edge T gives `eng_rst`=0 for cycles T+1…T+LATENCY.
- `res_bus` is sampled at edge T+LATENCY.
- `m_valid` rises in cycle T+LATENCY+1.
- The minimum frame period is 25 + LATENCY + 4 cycles. `s_ready` rises the cycle after the final output handshake.
- Reset asserted mid-frame (any state): partial operands are discarded (buses cleared), pending results are dropped, and the block returns to LOAD.
- `s_valid` held high during RUN/SEND has no effect. `m_ready` held low stalls SEND indefinitely.

## Configuration
- `FRONTEND_FILTER_REUSE_EN` defined
  - The first frame after reset carries 25 bytes.
  - Later frames carry 16 activation bytes only. The LOAD → RUN transition happens at `cnt`=15, and `flt_bus` retains its prior value.
  - Reset clears the retained filter and forces the next frame back to 25 bytes.
- Undefined: every frame carries 25 bytes.

## Structure
- Shared package `systolic_pkg` holds:
  - DATA_W, N_ACT=16, N_FLT=9, N_RES=4;
  - the state enum (LOAD, RUN, SEND);
  - bus index helper constants.
- Sub-module `systolic_result_serializer` contains the result register, `idx` counter and m_* handshake. It is loaded by a single capture strobe and pulses done after the last handshake.

## Test plan
- Engine stub returns constant `res_bus`=32'hA1B2C3D4, LATENCY=12.
- Load scenario
  - Stimulus: send bytes 252,165,199,27,93,28,86,176,149,110,113,249,234,207,29,30 then 181,176,207,111,248,115,64,95,253 with `s_valid` always high.
  - Response: `act_bus`[127:120]=252 and [7:0]=30; `flt_bus`[71:64]=181 and [7:0]=253; `eng_rst` low for exactly 12 cycles.
- Drain scenario
  - Stimulus: `m_ready`=1 after the load scenario.
  - Response: `m_data` = A1, B2, C3, D4 on consecutive cycles; `m_last` only on D4; `s_ready`=1 on the next cycle.
- Backpressure scenario
  - Stimulus: `m_ready` low for 5 cycles at B2, and `s_valid` toggled every other cycle during LOAD.
  - Response: B2 stays stable for all 5 stall cycles; operand bytes land at the correct indices; no byte is lost or duplicated.
- Reset mid-frame scenario
  - Stimulus: drive `rst`=0 after 10 bytes, then send a full new frame.
  - Response: all outputs return to reset values; the new frame loads from i00.
- Mid-RUN reset scenario
  - Stimulus: drive `rst`=0 in the 6th RUN cycle.
  - Response: `eng_rst`=1 and `m_valid` never asserts for that frame.
- `FRONTEND_FILTER_REUSE_EN` scenario
  - Stimulus: a 25-byte frame followed by a 16-byte frame.
  - Response: the second frame enters RUN after 16 bytes; `flt_bus` is unchanged (181…253).
